// File: rtl/game_display_timing_pkg.sv
// Shared timing constants for the 800x600@60 raster feeding the pacman game.
// Holds the VGA timing set and the game window geometry.
package game_display_timing_pkg;

  function automatic int window_origin(input int visible, input int game, input int scale);
    return (visible - game * scale) / 2;
  endfunction

  typedef struct packed {
    int h_visible;
    int h_front;
    int h_sync;
    int h_back;
    int v_visible;
    int v_front;
    int v_sync;
    int v_back;
    int h_total;
    int v_total;
    int x0;
    int y0;
  } vga_timing_t;

  typedef struct packed {
    int game_w;
    int game_h;
    int scale;
  } pacman_geom_t;

  localparam pacman_geom_t PACMAN = '{game_w: 224, game_h: 288, scale: 2};

  localparam vga_timing_t VGA = '{
    h_visible: 800, h_front: 40, h_sync: 128, h_back: 88,
    v_visible: 600, v_front: 1,  v_sync: 4,   v_back: 23,
    h_total:   800 + 40 + 128 + 88,
    v_total:   600 + 1 + 4 + 23,
    x0:        window_origin(800, 224, 2),
    y0:        window_origin(600, 288, 2)
  };

endpackage

// File: rtl/game_display_timing_scale_counter.sv
// Divide-by-SCALE coordinate counter: tracks the game coordinate of the
// current raster position along one axis, with a phase-zero flag.
module scale_counter #(
  parameter int SCALE   = 2,
  parameter int COORD_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic               load_zero_i,
  input  logic               advance_i,
  output logic [COORD_W-1:0] coord_o,
  output logic               phase_zero_o
);

  localparam int PW = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(SCALE - 1);

  logic [PW-1:0]      phase_q, phase_d;
  logic [COORD_W-1:0] coord_q, coord_d;

  always_comb begin
    phase_d = phase_q;
    coord_d = coord_q;
    if (en_i) begin
      if (load_zero_i) begin
        phase_d = '0;
        coord_d = '0;
      end else if (advance_i) begin
        if (phase_q == PHASE_LAST) begin
          phase_d = '0;
          coord_d = coord_q + 1'b1;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q <= '0;
      coord_q <= '0;
    end else begin
      phase_q <= phase_d;
      coord_q <= coord_d;
    end
  end

  assign coord_o      = coord_q;
  assign phase_zero_o = (phase_q == '0);

endmodule

// File: rtl/game_display_timing.sv
// Raster timing generator with centred, upscaled game window coordinates.
// Define GAME_TIMING_BORDER_EN to add the 'border' output.
module game_display_timing
  import game_display_timing_pkg::*;
#(
  parameter int H_VISIBLE = VGA.h_visible,
  parameter int H_FRONT   = VGA.h_front,
  parameter int H_SYNC    = VGA.h_sync,
  parameter int H_BACK    = VGA.h_back,
  parameter int V_VISIBLE = VGA.v_visible,
  parameter int V_FRONT   = VGA.v_front,
  parameter int V_SYNC    = VGA.v_sync,
  parameter int V_BACK    = VGA.v_back,
  parameter int GAME_W    = PACMAN.game_w,
  parameter int GAME_H    = PACMAN.game_h,
  parameter int SCALE     = PACMAN.scale,
  parameter bit SYNC_POL  = 1'b1
) (
  input  logic                      vga_pix_clk,
  input  logic                      rst_n,
  output logic                      hsync,
  output logic                      vsync,
  output logic [$clog2(GAME_W)-1:0] sx,
  output logic [$clog2(GAME_H)-1:0] sy,
  output logic                      game_pix_stb,
  output logic                      frame_stb,
  output logic                      display_enabled
`ifdef GAME_TIMING_BORDER_EN
  ,
  output logic                      border
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int X0  = window_origin(H_VISIBLE, GAME_W, SCALE);
  localparam int Y0  = window_origin(V_VISIBLE, GAME_H, SCALE);
  localparam int HW  = $clog2(H_TOTAL);
  localparam int VW  = $clog2(V_TOTAL);
  localparam int SXW = $clog2(GAME_W);
  localparam int SYW = $clog2(GAME_H);

  localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END   = HW'(H_VISIBLE);
  localparam logic [HW-1:0] H_WIN_START = HW'(X0);
  localparam logic [HW-1:0] H_WIN_LAST  = HW'(X0 + GAME_W * SCALE - 1);
  localparam logic [HW-1:0] H_WIN_END   = HW'(X0 + GAME_W * SCALE);
  localparam logic [HW-1:0] H_SYNC_BEG  = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] H_SYNC_END  = HW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END   = VW'(V_VISIBLE);
  localparam logic [VW-1:0] V_WIN_START = VW'(Y0);
  localparam logic [VW-1:0] V_WIN_LAST  = VW'(Y0 + GAME_H * SCALE - 1);
  localparam logic [VW-1:0] V_WIN_END   = VW'(Y0 + GAME_H * SCALE);
  localparam logic [VW-1:0] V_SYNC_BEG  = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] V_SYNC_END  = VW'(V_VISIBLE + V_FRONT + V_SYNC);

  if (GAME_W * SCALE > H_VISIBLE || GAME_H * SCALE > V_VISIBLE) begin : g_bad_geometry
    $error("game_display_timing: scaled game window does not fit the visible area");
  end

  logic [HW-1:0]  hc_q, hc_d;
  logic [VW-1:0]  vc_q, vc_d;
  logic           h_wrap, h_in, v_in, in_win, x_adv, y_adv;
  logic [SXW-1:0] x_coord;
  logic [SYW-1:0] y_coord;
  logic           x_phase_zero, unused_y_phase;

  always_comb begin
    h_wrap = (hc_q == H_LAST);
    hc_d   = h_wrap ? '0 : hc_q + 1'b1;
    vc_d   = vc_q;
    if (h_wrap) begin
      vc_d = (vc_q == V_LAST) ? '0 : vc_q + 1'b1;
    end
    h_in   = (hc_q >= H_WIN_START) && (hc_q < H_WIN_END);
    v_in   = (vc_q >= V_WIN_START) && (vc_q < V_WIN_END);
    in_win = h_in && v_in;
    // Advance only while the next position stays inside the window; anywhere
    // else the counter parks at zero so entering the window starts clean.
    x_adv  = (hc_q >= H_WIN_START) && (hc_q < H_WIN_LAST);
    y_adv  = (vc_q >= V_WIN_START) && (vc_q < V_WIN_LAST);
  end

  scale_counter #(.SCALE(SCALE), .COORD_W(SXW)) u_x_scale (
    .clk_i        (vga_pix_clk),
    .rst_ni       (rst_n),
    .en_i         (1'b1),
    .load_zero_i  (!x_adv),
    .advance_i    (x_adv),
    .coord_o      (x_coord),
    .phase_zero_o (x_phase_zero)
  );

  scale_counter #(.SCALE(SCALE), .COORD_W(SYW)) u_y_scale (
    .clk_i        (vga_pix_clk),
    .rst_ni       (rst_n),
    .en_i         (h_wrap),
    .load_zero_i  (!y_adv),
    .advance_i    (y_adv),
    .coord_o      (y_coord),
    .phase_zero_o (unused_y_phase)
  );

  logic           hsync_q, vsync_q, pix_stb_q, frame_stb_q, de_q, border_q;
  logic           hsync_d, vsync_d, pix_stb_d, frame_stb_d, de_d, border_d;
  logic [SXW-1:0] sx_q, sx_d;
  logic [SYW-1:0] sy_q, sy_d;

  always_comb begin
    hsync_d     = ((hc_q >= H_SYNC_BEG) && (hc_q < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_d     = ((vc_q >= V_SYNC_BEG) && (vc_q < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    de_d        = in_win;
    sx_d        = in_win ? x_coord : '0;
    sy_d        = in_win ? y_coord : '0;
    pix_stb_d   = in_win && x_phase_zero;
    frame_stb_d = (hc_q == H_WIN_START) && (vc_q == V_WIN_START);
    border_d    = (hc_q < H_ACT_END) && (vc_q < V_ACT_END) && !in_win;
  end

  // Outputs are registered from the counter state, so every qualifier for one
  // raster position appears together one cycle after that position.
  always_ff @(posedge vga_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      hc_q        <= '0;
      vc_q        <= '0;
      hsync_q     <= ~SYNC_POL;
      vsync_q     <= ~SYNC_POL;
      sx_q        <= '0;
      sy_q        <= '0;
      pix_stb_q   <= 1'b0;
      frame_stb_q <= 1'b0;
      de_q        <= 1'b0;
      border_q    <= 1'b0;
    end else begin
      hc_q        <= hc_d;
      vc_q        <= vc_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      pix_stb_q   <= pix_stb_d;
      frame_stb_q <= frame_stb_d;
      de_q        <= de_d;
      border_q    <= border_d;
    end
  end

  assign hsync           = hsync_q;
  assign vsync           = vsync_q;
  assign sx              = sx_q;
  assign sy              = sy_q;
  assign game_pix_stb    = pix_stb_q;
  assign frame_stb       = frame_stb_q;
  assign display_enabled = de_q;
`ifdef GAME_TIMING_BORDER_EN
  assign border          = border_q;
`else
  logic unused_border;
  assign unused_border = border_q;
`endif

endmodule

// File: tb/tb_game_display_timing.sv
// Directed bench for game_display_timing: a shrunken raster for full-frame
// behaviour plus the default 800x600 raster for the first frame strobe and line 12.
module tb_game_display_timing;

  // Shrunken raster: line 28, frame 21 lines (588 cycles), window origin (4,3),
  // window hc [4,16), vc [3,13), hsync hc [22,25), vsync vc [17,19).
  localparam int S_HT    = 28;
  localparam int S_FRAME = 588;
  localparam int D_HT    = 1056;
  localparam int REC_N   = 2 * S_FRAME;
  localparam int RUN_N   = 14000;

  typedef struct {
    logic       hs, vs, pix, frm, de, bd;
    logic [2:0] sx, sy;
  } smallRec_t;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       hsS, vsS, pixS, frmS, deS;
  logic [2:0] sxS, syS;
  logic       hsD, vsD, pixD, frmD, deD;
  logic [7:0] sxD;
  logic [8:0] syD;
`ifdef GAME_TIMING_BORDER_EN
  logic       bdS, bdD;
`endif

  always #5 clock = ~clock;

  game_display_timing #(
    .H_VISIBLE(20), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(16), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .GAME_W(6), .GAME_H(5), .SCALE(2), .SYNC_POL(1'b1)
  ) dutSmall (
    .vga_pix_clk(clock), .rst_n(rst_n), .hsync(hsS), .vsync(vsS),
    .sx(sxS), .sy(syS), .game_pix_stb(pixS), .frame_stb(frmS),
    .display_enabled(deS)
`ifdef GAME_TIMING_BORDER_EN
    , .border(bdS)
`endif
  );

  game_display_timing dutFull (
    .vga_pix_clk(clock), .rst_n(rst_n), .hsync(hsD), .vsync(vsD),
    .sx(sxD), .sy(syD), .game_pix_stb(pixD), .frame_stb(frmD),
    .display_enabled(deD)
`ifdef GAME_TIMING_BORDER_EN
    , .border(bdD)
`endif
  );

  int checkCount = 0;
  int failCount  = 0;
  int p = 0;
  smallRec_t recS [0:REC_N-1];

  int firstFrmD = -1, frmCntD = 0, pixCntD = 0, firstPixHcD = -1, lastPixHcD = -1;
  int deCntD = 0, hsCntD = 0, firstHsHcD = -1;
  int sxD177 = -1, sxD622 = -1, sxD623 = -1, sxD624 = -1, deD624 = -1;
`ifdef GAME_TIMING_BORDER_EN
  int bdD12Cnt = 0, bdD5Cnt = 0, bdD12Hc175 = -1, bdD12Hc176 = -1, bdD12Hc624 = -1;
`endif

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Advance one cycle, then record both rasters at output position p.
  task automatic applyStimulus();
    int hcD, vcD;
    @(negedge clock);
    if (p < REC_N) begin
      recS[p].hs  = hsS;  recS[p].vs  = vsS;  recS[p].pix = pixS;
      recS[p].frm = frmS; recS[p].de  = deS;  recS[p].sx  = sxS;
      recS[p].sy  = syS;  recS[p].bd  = 1'b0;
`ifdef GAME_TIMING_BORDER_EN
      recS[p].bd  = bdS;
`endif
    end
    if (p < RUN_N) begin
      hcD = p % D_HT;
      vcD = p / D_HT;
      if (frmD) begin
        frmCntD++;
        if (firstFrmD < 0) firstFrmD = p;
      end
      if (vcD == 0 && hsD) begin
        hsCntD++;
        if (firstHsHcD < 0) firstHsHcD = hcD;
      end
      if (vcD == 12) begin
        if (pixD) begin
          pixCntD++;
          if (firstPixHcD < 0) firstPixHcD = hcD;
          lastPixHcD = hcD;
        end
        if (deD) deCntD++;
        if (hcD == 177) sxD177 = int'(sxD);
        if (hcD == 622) sxD622 = int'(sxD);
        if (hcD == 623) sxD623 = int'(sxD);
        if (hcD == 624) begin
          sxD624 = int'(sxD);
          deD624 = int'(deD);
        end
      end
`ifdef GAME_TIMING_BORDER_EN
      if (vcD == 12 && bdD) bdD12Cnt++;
      if (vcD == 5 && bdD) bdD5Cnt++;
      if (vcD == 12 && hcD == 175) bdD12Hc175 = int'(bdD);
      if (vcD == 12 && hcD == 176) bdD12Hc176 = int'(bdD);
      if (vcD == 12 && hcD == 624) bdD12Hc624 = int'(bdD);
`endif
    end
    p++;
  endtask

  function automatic int countSmall(input int first, input int last, input int sel);
    int n = 0;
    for (int i = first; i <= last; i++) begin
      case (sel)
        0: n += int'(recS[i].hs);
        1: n += int'(recS[i].vs);
        2: n += int'(recS[i].pix);
        3: n += int'(recS[i].frm);
        4: n += int'(recS[i].de);
        default: n += int'(recS[i].bd);
      endcase
    end
    return n;
  endfunction

  function automatic int firstSmall(input int first, input int last, input int sel);
    for (int i = first; i <= last; i++) begin
      if ((sel == 0 && recS[i].hs) || (sel == 1 && recS[i].vs) || (sel == 3 && recS[i].frm))
        return i;
    end
    return -1;
  endfunction

  initial begin
    int found;
    $display("[TB] starting game_display_timing bench");

    repeat (3) @(negedge clock);
    checkOutput("rst_hsync", hsS, 1'b0);
    checkOutput("rst_vsync", vsS, 1'b0);
    checkOutput("rst_de", deS, 1'b0);
    checkOutput("rst_frame_stb", frmS, 1'b0);
    checkOutput("rst_pix_stb", pixS, 1'b0);
    checkOutput("rst_sx_sy", {sxS, syS}, 6'd0);
    checkOutput("rst_full_sync", {hsD, vsD, deD}, 3'b000);
    rst_n = 1'b1;

    for (int i = 0; i < RUN_N; i++) applyStimulus();

    // Shrunken raster, first output cycle and two full frames
    checkOutput("first_cycle_hs_vs_de", {recS[0].hs, recS[0].vs, recS[0].de}, 3'b000);
    checkOutput("frame_stb_count_2frames", countSmall(0, REC_N - 1, 3), 2);
    checkOutput("frame_stb_first", firstSmall(0, REC_N - 1, 3), 88);
    checkOutput("frame_stb_second", firstSmall(89, REC_N - 1, 3), 88 + S_FRAME);
    checkOutput("hsync_len_line0", countSmall(0, S_HT - 1, 0), 3);
    checkOutput("hsync_start_line0", firstSmall(0, S_HT - 1, 0), 22);
    checkOutput("vsync_cycles_frame0", countSmall(0, S_FRAME - 1, 1), 56);
    checkOutput("vsync_start_frame0", firstSmall(0, S_FRAME - 1, 1), 17 * S_HT);
    checkOutput("pix_stb_line3", countSmall(84, 111, 2), 6);
    checkOutput("de_len_line3", countSmall(84, 111, 4), 12);
    checkOutput("pix_stb_frame0", countSmall(0, S_FRAME - 1, 2), 60);
    checkOutput("pix_stb_hc5_off", recS[89].pix, 1'b0);
    checkOutput("pix_stb_hc14_on", recS[98].pix, 1'b1);
    checkOutput("sx_hc9", recS[93].sx, 3'd2);
    checkOutput("sx_hc15_last", recS[99].sx, 3'd5);
    checkOutput("sx_de_hc16_close", {recS[100].sx, recS[100].de}, 4'd0);
    checkOutput("sy_line5", recS[150].sy, 3'd1);
    checkOutput("sy_line11", recS[318].sy, 3'd4);
    checkOutput("sy_line12", recS[346].sy, 3'd4);
    checkOutput("sy_de_line13_close", {recS[374].sy, recS[374].de}, 4'd0);
`ifdef GAME_TIMING_BORDER_EN
    checkOutput("border_line3_count", countSmall(84, 111, 5), 8);
    checkOutput("border_line1_count", countSmall(28, 55, 5), 20);
    checkOutput("border_line17_count", countSmall(17 * S_HT, 18 * S_HT - 1, 5), 0);
    checkOutput("border_line3_hc3", recS[87].bd, 1'b1);
    checkOutput("border_line3_hc4", recS[88].bd, 1'b0);
    checkOutput("border_line3_hc16", recS[100].bd, 1'b1);
    checkOutput("border_line3_hc20", recS[104].bd, 1'b0);
    checkOutput("full_border_line12_count", bdD12Cnt, 352);
    checkOutput("full_border_line5_count", bdD5Cnt, 800);
    checkOutput("full_border_hc175_176_624", {bdD12Hc175[0], bdD12Hc176[0], bdD12Hc624[0]}, 3'b101);
`endif

    // Default 800x600 raster
    checkOutput("full_frame_stb_first", firstFrmD, 12848);
    checkOutput("full_frame_stb_count", frmCntD, 1);
    checkOutput("full_hsync_len_line0", hsCntD, 128);
    checkOutput("full_hsync_start_line0", firstHsHcD, 840);
    checkOutput("full_pix_stb_line12", pixCntD, 224);
    checkOutput("full_pix_first_hc", firstPixHcD, 176);
    checkOutput("full_pix_last_hc", lastPixHcD, 622);
    checkOutput("full_de_len_line12", deCntD, 448);
    checkOutput("full_sx_hc177", sxD177, 0);
    checkOutput("full_sx_hc622", sxD622, 223);
    checkOutput("full_sx_hc623", sxD623, 223);
    checkOutput("full_sx_de_hc624", {sxD624[7:0], deD624[0]}, 9'd0);

    // Mid-frame reset on the shrunken raster at hc=10, vc=8
    applyStimulus();
    for (int i = 0; i < S_FRAME && ((p - 1) % S_FRAME) != 234; i++) applyStimulus();
    checkOutput("midframe_pre_de", deS, 1'b1);
    checkOutput("midframe_pre_sx", sxS, 3'd3);
    rst_n = 1'b0;
    #1;
    checkOutput("midframe_rst_de_pix", {deS, pixS, frmS}, 3'b000);
    checkOutput("midframe_rst_sx_sy", {sxS, syS}, 6'd0);
    checkOutput("midframe_rst_sync", {hsS, vsS}, 2'b00);
    repeat (3) @(negedge clock);
    rst_n = 1'b1;
    found = -1;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clock);
      if (n == 0) checkOutput("midframe_restart_origin", {deS, sxS, syS, hsS}, 8'd0);
      if (frmS) begin
        found = n;
        break;
      end
    end
    checkOutput("midframe_next_frame_stb", found, 88);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
